// File: rtl/mips_bus_initiator_if.sv
// CPU request/response and memory-bus signal bundle for mips_bus_initiator.
// master: the initiator; slave: the CPU core plus the bus responder.
interface mips_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_size, req_signed, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output address, read, write,
    output writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_size, req_signed, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  address, read, write,
    input  writedata, byteenable
  );
endinterface

// File: rtl/mips_bus_initiator.sv
// Bus master: one CPU load/store -> one waitrequest-stalled bus transfer.
// Ports: clk, reset (async, active-low), bus (mips_bus_initiator_if.master).
// Optional macro BUS_TIMEOUT_EN: abort after TIMEOUT_CYCLES stall cycles.
module mips_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] RESET_ADDR     = 32'hBFC00000
) (
  input logic                  clk,
  input logic                  reset,
  mips_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_addr, w_addr;
  logic        r_read, w_read;
  logic        r_write, w_write;
  logic [3:0]  r_be, w_be;
  logic [31:0] r_wdata, w_wdata;
  logic [1:0]  r_size, w_size;
  logic        r_signed, w_signed;
  logic [1:0]  r_lane, w_lane;
  logic [31:0] r_rdata, w_rdata;
  logic        r_err, w_err;

  logic        w_ready;
  logic        w_acc;
  logic        w_done;
  logic        w_timeout;
  logic [1:0]  w_a;
  logic [3:0]  w_be_req;
  logic [31:0] w_wd_req;
  logic        w_bad;
  logic [15:0] w_shift;
  logic [31:0] w_ext;

  // Gated by reset so req_ready is low while reset is held.
  assign w_ready = (r_state == IDLE) & reset;
  assign w_acc   = bus.req_valid & w_ready;
  assign w_done  = (r_read | r_write) & ~bus.waitrequest;
  assign w_a     = bus.req_addr[1:0];

  always_comb begin
    w_be_req = 4'b0000;
    w_wd_req = bus.req_wdata;
    w_bad    = 1'b0;
    unique case (1'b1)
      bus.req_size == 2'd0: begin
        w_be_req = 4'b0001 << w_a;
        w_wd_req = {4{bus.req_wdata[7:0]}};
      end
      bus.req_size == 2'd1: begin
        w_be_req = 4'b0011 << w_a;
        w_wd_req = {2{bus.req_wdata[15:0]}};
        w_bad    = w_a[0];
      end
      bus.req_size == 2'd2: begin
        w_be_req = 4'b1111;
        w_bad    = |w_a;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Move the addressed lane(s) down to bit 0, then extend.
  assign w_shift = 16'(bus.readdata >> {r_lane, 3'b000});

  always_comb begin
    w_ext = bus.readdata;
    unique case (1'b1)
      r_size == 2'd0:
        w_ext = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
      r_size == 2'd1:
        w_ext = {{16{r_signed & w_shift[15]}}, w_shift};
      default: w_ext = bus.readdata;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state != BUS) begin
      r_cnt <= '0;
    end else if (bus.waitrequest) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Fires on the edge that closes the last tolerated stall cycle.
  assign w_timeout = (r_state == BUS) & bus.waitrequest &
                     (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  // No stall counter: a stalled transfer waits forever.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_state  = r_state;
    w_addr   = r_addr;
    w_read   = r_read;
    w_write  = r_write;
    w_be     = r_be;
    w_wdata  = r_wdata;
    w_size   = r_size;
    w_signed = r_signed;
    w_lane   = r_lane;
    w_rdata  = r_rdata;
    w_err    = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_rdata = '0;
          if (w_bad) begin
            w_state = RESP;
            w_err   = 1'b1;
          end else begin
            w_state  = BUS;
            w_err    = 1'b0;
            w_addr   = {bus.req_addr[31:2], 2'b00};
            w_read   = ~bus.req_write;
            w_write  = bus.req_write;
            w_be     = w_be_req;
            w_wdata  = w_wd_req;
            w_size   = bus.req_size;
            w_signed = bus.req_signed;
            w_lane   = w_a;
          end
        end
      end
      BUS: begin
        if (w_done || w_timeout) begin
          w_state = RESP;
          w_addr  = RESET_ADDR;
          w_read  = 1'b0;
          w_write = 1'b0;
          w_be    = '0;
          w_wdata = '0;
          w_err   = ~w_done;
          w_rdata = (w_done & r_read) ? w_ext : '0;
        end
      end
      RESP: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_addr   <= RESET_ADDR;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_addr   <= w_addr;
      r_read   <= w_read;
      r_write  <= w_write;
      r_be     <= w_be;
      r_wdata  <= w_wdata;
      r_size   <= w_size;
      r_signed <= w_signed;
      r_lane   <= w_lane;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.address    = r_addr;
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.writedata  = r_wdata;
  assign bus.byteenable = r_be;

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Directed bench for mips_bus_initiator.
// Define BUS_TIMEOUT_EN to add the stall-timeout case.
module tb_mips_bus_initiator;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mips_bus_initiator_if bif ();

  mips_bus_initiator #(
    .TIMEOUT_CYCLES(8),
    .RESET_ADDR    (32'hBFC00000)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        wr,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] wd
  );
    bif.req_valid  = 1'b1;
    bif.req_write  = wr;
    bif.req_addr   = addr;
    bif.req_size   = size;
    bif.req_signed = sgn;
    bif.req_wdata  = wd;
  endtask

  // Zero-wait load: strobe cycle, response cycle, back to idle.
  task automatic load_chk(
    input string       tag,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] rd,
    input logic [3:0]  be,
    input logic [31:0] exp
  );
    bif.waitrequest = 1'b0;
    bif.readdata    = rd;
    chk({tag, ".rdy"}, 32'(bif.req_ready), 32'd1);
    drive(1'b0, addr, size, sgn, 32'h0);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk({tag, ".rd"}, 32'(bif.read), 32'd1);
    chk({tag, ".wr"}, 32'(bif.write), 32'd0);
    chk({tag, ".adr"}, bif.address,
        {addr[31:2], 2'b00});
    chk({tag, ".be"}, 32'(bif.byteenable), 32'(be));
    @(negedge clk);
    chk({tag, ".rv"}, 32'(bif.resp_valid), 32'd1);
    chk({tag, ".rdat"}, bif.resp_rdata, exp);
    chk({tag, ".err"}, 32'(bif.resp_err), 32'd0);
    chk({tag, ".rd0"}, 32'(bif.read), 32'd0);
    @(negedge clk);
    chk({tag, ".rv0"}, 32'(bif.resp_valid), 32'd0);
  endtask

  task automatic err_chk(
    input string       tag,
    input logic [31:0] addr,
    input logic [1:0]  size
  );
    drive(1'b0, addr, size, 1'b0, 32'h0);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk({tag, ".strb"},
        32'(bif.read | bif.write), 32'd0);
    chk({tag, ".rv"}, 32'(bif.resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(bif.resp_err), 32'd1);
    @(negedge clk);
    chk({tag, ".rv0"}, 32'(bif.resp_valid), 32'd0);
  endtask

  initial begin
    int n_wr;
    int n_rv;
    n_vec           = 0;
    n_err           = 0;
    reset           = 1'b0;
    bif.req_valid   = 1'b0;
    bif.req_write   = 1'b0;
    bif.req_addr    = '0;
    bif.req_size    = '0;
    bif.req_signed  = 1'b0;
    bif.req_wdata   = '0;
    bif.waitrequest = 1'b0;
    bif.readdata    = '0;

    repeat (2) @(negedge clk);
    chk("rst.rd", 32'(bif.read), 32'd0);
    chk("rst.wr", 32'(bif.write), 32'd0);
    chk("rst.adr", bif.address, 32'hBFC00000);
    chk("rst.be", 32'(bif.byteenable), 32'd0);
    chk("rst.wd", bif.writedata, 32'd0);
    chk("rst.rdy", 32'(bif.req_ready), 32'd0);
    chk("rst.rv", 32'(bif.resp_valid), 32'd0);
    chk("rst.rdat", bif.resp_rdata, 32'd0);
    chk("rst.err", 32'(bif.resp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    load_chk("ldw", 32'hBFC00004, 2'd2, 1'b0,
             32'h12345678, 4'b1111, 32'h12345678);
    load_chk("ldbs", 32'hBFC00003, 2'd0, 1'b1,
             32'h80FF0011, 4'b1000, 32'hFFFFFF80);
    load_chk("ldbu", 32'hBFC00003, 2'd0, 1'b0,
             32'h80FF0011, 4'b1000, 32'h00000080);
    load_chk("ldhs", 32'hBFC00002, 2'd1, 1'b1,
             32'h9ABC1234, 4'b1100, 32'hFFFF9ABC);
    load_chk("ldhu", 32'hBFC00000, 2'd1, 1'b0,
             32'h9ABC9234, 4'b0011, 32'h00009234);
    load_chk("ldb1", 32'hBFC00011, 2'd0, 1'b1,
             32'h00007F00, 4'b0010, 32'h0000007F);

    // Half store stalled for 5 cycles.
    bif.waitrequest = 1'b1;
    drive(1'b1, 32'hBFC00002, 2'd1, 1'b0,
          32'h0000ABCD);
    @(negedge clk);
    bif.req_valid = 1'b0;
    n_wr = 0;
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      if (bif.write) n_wr++;
      chk("sth.wd", bif.writedata, 32'hABCDABCD);
      chk("sth.be", 32'(bif.byteenable), 32'hC);
      chk("sth.rd", 32'(bif.read), 32'd0);
      if (i == 5) bif.waitrequest = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (bif.resp_valid) begin
        n_rv++;
        chk("sth.rdat", bif.resp_rdata, 32'd0);
        chk("sth.err", 32'(bif.resp_err), 32'd0);
      end
      if (bif.write) n_wr++;
      @(negedge clk);
    end
    chk("sth.nwr", 32'(n_wr), 32'd6);
    chk("sth.nrv", 32'(n_rv), 32'd1);

    // Zero-wait byte store at lane 1.
    drive(1'b1, 32'hBFC00021, 2'd0, 1'b0,
          32'h1234565A);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("stb.wr", 32'(bif.write), 32'd1);
    chk("stb.adr", bif.address, 32'hBFC00020);
    chk("stb.be", 32'(bif.byteenable), 32'h2);
    chk("stb.wd", bif.writedata, 32'h5A5A5A5A);
    @(negedge clk);
    chk("stb.rv", 32'(bif.resp_valid), 32'd1);
    @(negedge clk);

    err_chk("misw", 32'hBFC00001, 2'd2);
    err_chk("mish", 32'hBFC00003, 2'd1);
    err_chk("rsvd", 32'hBFC00000, 2'd3);

    // Reset in the middle of a stalled read.
    bif.waitrequest = 1'b1;
    drive(1'b0, 32'hBFC00008, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("rmt.rd", 32'(bif.read), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rmt.rd0", 32'(bif.read), 32'd0);
    chk("rmt.adr", bif.address, 32'hBFC00000);
    chk("rmt.rv", 32'(bif.resp_valid), 32'd0);
    chk("rmt.rdy", 32'(bif.req_ready), 32'd0);
    @(negedge clk);
    bif.waitrequest = 1'b0;
    reset = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 3; i++) begin
      if (bif.resp_valid) n_rv++;
      @(negedge clk);
    end
    chk("rmt.nrv", 32'(n_rv), 32'd0);
    load_chk("rmt.ld", 32'hBFC0000C, 2'd2, 1'b0,
             32'hAABBCCDD, 4'b1111, 32'hAABBCCDD);

`ifdef BUS_TIMEOUT_EN
    bif.waitrequest = 1'b1;
    drive(1'b0, 32'hBFC00010, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    bif.req_valid = 1'b0;
    n_wr = 0;
    n_rv = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.read) n_wr++;
      if (bif.resp_valid) begin
        n_rv++;
        chk("to.err", 32'(bif.resp_err), 32'd1);
        chk("to.rdat", bif.resp_rdata, 32'd0);
      end
      @(negedge clk);
    end
    chk("to.nrd", 32'(n_wr), 32'd8);
    chk("to.nrv", 32'(n_rv), 32'd1);
    bif.waitrequest = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_bus_initiator.md
Name: mips_bus_initiator

Overview:
Bus-master end of the CPU memory bus. It converts single CPU-side load/store requests into read/write transfers on the waitrequest-stalled memory bus (address, read, write, writedata, byteenable, waitrequest, readdata). It sits between the core's load/store/fetch logic and the bus ports of mips_cpu_bus. It handles byte-lane generation, stall handling, and alignment of read data.

Parameters:
TIMEOUT_CYCLES, 256, stall cycles tolerated before a transfer is aborted (used only with the optional feature)
RESET_ADDR, 32'hBFC00000, value driven on address while idle and after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle (req_valid & req_ready)
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
req_signed  in  1  sign-extend a sub-word load
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores
resp_err  out  1  misaligned, reserved size, or timeout
address  out  32  bus address, word-aligned ([1:0] = 0)
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  32  lane-positioned store data
byteenable  out  4  byteenable[i] qualifies bits [8i+7:8i]
waitrequest  in  1  responder stall
readdata  in  32  responder data, valid in the completing cycle

Behaviour:
- Reset is asynchronous and active-low; the clock and reset are named clk and reset.
- While reset is low, all of the following hold immediately: state = IDLE, read = 0, write = 0, byteenable = 0, writedata = 0, address = RESET_ADDR, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Reset asserted mid-transfer abandons the transfer. No response is issued.
- States are IDLE, BUS, RESP.
- IDLE: req_ready = 1.
  - When a request is accepted and it is misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or req_size = 3, go to RESP with resp_err = 1. No bus strobe is issued.
  - Otherwise latch the request, drive address = {req_addr[31:2], 2'b00}, set read or write, and go to BUS.
- Byte lanes, where a = addr[1:0]:
  - byte: byteenable = 1 << a.
  - half: byteenable = 4'b0011 << a.
  - word: byteenable = 4'b1111.
- Store data replication: byte → 4 copies of wdata[7:0]; half → 2 copies of wdata[15:0]; word as-is.
- BUS: address, read/write, byteenable and writedata are held stable.
  - The transfer completes at the first rising edge where the strobe is 1 and waitrequest = 0. At that edge, capture readdata, drop the strobe, and go to RESP.
  - Minimum latency is 1 cycle in BUS (acceptance edge → completion edge when waitrequest is 0). A request can therefore complete at most every 3 cycles.
- Load data extraction: byte → readdata[8a+7:8a]; half → readdata[8a+15:8a]. Zero- or sign-extend per req_signed. Word loads pass readdata unchanged.
- RESP: resp_valid = 1 for exactly one cycle, with resp_rdata and resp_err valid. req_ready = 0. Then go to IDLE.
- resp_valid = 0 in all other states.
- read and write are never both 1.
- Strobes are never asserted in IDLE or RESP.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined: a 16-bit stall counter clears on entry to BUS and increments each cycle that waitrequest = 1. When it reaches TIMEOUT_CYCLES, the strobe drops, state goes to RESP, resp_err = 1 and resp_rdata = 0.
- When undefined: there is no counter, BUS waits indefinitely, and resp_err reports only alignment and size errors.

Test Plan:
1. Word load: addr BFC00004, waitrequest = 0, readdata 12345678 → read = 1 for 1 cycle, address BFC00004, byteenable 1111, resp_rdata 12345678, resp_err = 0.
2. Signed byte load: addr BFC00003, readdata 80FF0011 → byteenable 1000, resp_rdata FFFFFF80. The same access with req_signed = 0 → 00000080.
3. Half store stalled: addr BFC00002, wdata 0000ABCD, waitrequest high 5 cycles → write held 6 cycles with writedata ABCDABCD and byteenable 1100 stable; a single resp_valid follows.
4. Misaligned word: addr BFC00001 → no read/write strobe, resp_valid with resp_err = 1 on the cycle after acceptance.
5. Reset low during a stalled read → read = 0 and address BFC00000 immediately, no resp_valid, and the next request is accepted normally.
6. BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and waitrequest stuck at 1 → strobe drops after 8 stall cycles, resp_err = 1, resp_rdata = 0.
